tilelink_ul_master: RTL and testbench
=====================================

# tilelink_ul_master

TileLink-UL initiator that turns single commands from a local requester into A-channel requests, then collects the D-channel responses. It is the requesting end of the 32-bit TL-UL link whose responding end is the formal dummy slave on the tile master port. It drives Get, PutFullData and PutPartialData, splits multi-beat Get responses into a registered response stream, and recovers from a lost response through a timeout and source tagging.

## Interface
- TIMEOUT, 256: cycles without a matching D beat before an error response is returned; 0 disables the timeout.
- MAX_SIZE, 6: largest Get size accepted, as log2 bytes; 6 is 64 B, which is 16 beats.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = Put, 0 = Get.
- cmd_address  in  32  byte address.
- cmd_size  in  4  log2 bytes.
- cmd_mask  in  4  write byte lanes.
- cmd_data  in  32  write data.
- channel_a_valid / channel_a_ready  out/in  1  A handshake.
- channel_a_bits_opcode  out  3  4 = Get, 0 = PutFullData, 1 = PutPartialData.
- channel_a_bits_param  out  3  always 0.
- channel_a_bits_size  out  4  request size.
- channel_a_bits_source  out  1  transaction tag.
- channel_a_bits_address  out  32  request address.
- channel_a_bits_mask  out  4  byte lanes.
- channel_a_bits_data  out  32  write data.
- channel_d_valid / channel_d_ready  in/out  1  D handshake.
- channel_d_bits_opcode  in  3  0 = AccessAck, 1 = AccessAckData.
- channel_d_bits_param  in  2  ignored.
- channel_d_bits_size  in  4  ignored.
- channel_d_bits_source  in  1  response tag.
- channel_d_bits_sink  in  1  ignored.
- channel_d_bits_addr_lo  in  2  ignored.
- channel_d_bits_data  in  32  read data.
- channel_d_bits_error  in  1  slave error.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_data  out  32  beat data; 0 for writes and for timeout.
- rsp_last  out  1  final beat of the transaction.
- rsp_error  out  1  error flag for the beat.

## Operation
- States:
  - IDLE: cmd_ready=1. A command handshake latches all cmd_* fields. It goes to REQ, or to ERR if the command is illegal.
  - REQ: channel_a_valid=1 with all channel_a_* fields stable until channel_a_ready. The handshake moves to WAIT.
  - WAIT: collects D beats.
  - ERR: drives a single rsp beat with error=1, last=1, data=0 until it is accepted, then returns to IDLE.
- Illegal commands, which issue no A request:
  - a write with cmd_size>2;
  - a Get with cmd_size>MAX_SIZE;
  - any access misaligned to its size.
- Opcode selection:
  - A Get always drives mask=4'hF.
  - A Put uses PutFullData when cmd_mask equals the natural mask for size and address; otherwise it uses PutPartialData.
  - Natural mask: size 0 gives 1<<addr[1:0]; size 1 gives 3<<addr[1:0]; size 2 gives 4'hF.
- Source tag:
  - A 1-bit register, reset value 0.
  - It toggles when a transaction ends, whether by the last beat or by timeout.
- Expected beats:
  - Get: max(1, 2^size/4).
  - Put: 1.
  - Tracked by a 5-bit beat counter that clears on entry to WAIT.
- channel_d_ready in WAIT is 1 when !rsp_valid || rsp_ready. It is 0 in every other state.
- Each D handshake in WAIT:
  - If source != tag, the beat is dropped silently as stale. The counter and timeout are unchanged.
  - Otherwise the output register loads rsp_data (0 for Put), the last flag (beat==expected-1), and the error flag.
  - rsp_error = channel_d_bits_error || opcode mismatch, where a Get expects 1 and a Put expects 0.
  - rsp_valid sets. The counter increments, and after the last beat the state returns to IDLE.
- Timeout counter:
  - Counts WAIT cycles since entry or since the last matching beat.
  - Reaching TIMEOUT loads an error beat with last=1 into the response register and returns to IDLE.
  - The timeout beat waits for a free register, i.e. it is delayed while rsp_valid&&!rsp_ready.
- The rsp register holds while rsp_valid && !rsp_ready. It clears on the handshake unless it is reloaded in the same cycle.

## Timing
- Reset values:
  - state IDLE, cmd_ready 1, channel_a_valid 0, channel_d_ready 0.
  - rsp_valid 0, rsp_data 0, rsp_last 0, rsp_error 0, tag 0.
  - channel_a_bits_* all 0.
- Reset deassertion is synchronised internally by the team's standard 2-flop release. Reset assertion mid-transaction immediately aborts to IDLE with no response.
- Latency with ready held high throughout:
  - cmd handshake at cycle 0, A valid at cycle 1, D beat accepted at cycle n, rsp_valid at cycle n+1.
  - Back-to-back D beats give back-to-back rsp beats, one per cycle.
- cmd_ready returns 1 in the cycle after the final beat loads. A new command can therefore overlap the previous response still being held.
- The A channel never drops valid or changes fields before its handshake.

## Test plan
- Get size 2 at address 0x100:
  - A shows opcode 4, mask F, source 0.
  - D returns 0xDEADBEEF with opcode 1.
  - Response is one beat with data DEADBEEF, last=1, error=0. Tag becomes 1.
- Get size 4 at address 0x40, with rsp_ready toggling every other cycle:
  - Response is 4 beats in order with last on beat 3.
  - channel_d_ready is low whenever the register is full. No beat is lost.
- Put with size 0, address 0x3, mask 8 -> opcode 0.
- Put with size 2, mask 4'b0101 -> opcode 1. D returns AccessAck with error=1 -> rsp_error=1, data 0.
- Illegal command write size 3 -> no A valid. ERR response returns with error=1 within 2 cycles.
- TIMEOUT=8 with no D response:
  - Error beat appears at WAIT+8.
  - A late D beat with the old source is accepted and dropped.
  - The next Get completes normally with the new tag.
- Reset asserted during WAIT with 2 of 4 beats received -> all outputs take reset values asynchronously; the next command works.

Source files
------------

// File: rtl/tilelink_ul_master.sv
// TileLink-UL initiator: turns single local commands into A-channel requests and
// returns D-channel beats through a registered response stream with timeout recovery.
`timescale 1ns/1ps

module tilelink_ul_master #(
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned MAX_SIZE = 6
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [3:0]  cmd_size,
  input  logic [3:0]  cmd_mask,
  input  logic [31:0] cmd_data,

  output logic        channel_a_valid,
  input  logic        channel_a_ready,
  output logic [2:0]  channel_a_bits_opcode,
  output logic [2:0]  channel_a_bits_param,
  output logic [3:0]  channel_a_bits_size,
  output logic        channel_a_bits_source,
  output logic [31:0] channel_a_bits_address,
  output logic [3:0]  channel_a_bits_mask,
  output logic [31:0] channel_a_bits_data,

  input  logic        channel_d_valid,
  output logic        channel_d_ready,
  input  logic [2:0]  channel_d_bits_opcode,
  input  logic [1:0]  channel_d_bits_param,
  input  logic [3:0]  channel_d_bits_size,
  input  logic        channel_d_bits_source,
  input  logic        channel_d_bits_sink,
  input  logic [1:0]  channel_d_bits_addr_lo,
  input  logic [31:0] channel_d_bits_data,
  input  logic        channel_d_bits_error,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_error
);

  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  localparam int unsigned   TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

  state_t        state, state_next;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic          tag;
  logic          req_write;
  logic [4:0]    exp_last;
  logic [4:0]    beat_cnt;
  logic [TW-1:0] timer;
  logic          err_loaded;

  logic cmd_fire, d_fire, d_match, rsp_free, beat_last;
  logic timeout_fire, err_load, txn_done;
  logic unused_d_fields;

  // Assertion clears both flops at once; release ripples through two clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  function automatic logic [3:0] natural_mask(input logic [3:0] size, input logic [1:0] lo);
    case (size)
      4'd0:    return 4'b0001 << lo;
      4'd1:    return 4'b0011 << lo;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic cmd_illegal(input logic wr, input logic [3:0] size,
                                       input logic [31:0] addr);
    logic [31:0] align;
    align = (32'd1 << size) - 32'd1;
    return (wr && size > 4'd2) || (!wr && {28'd0, size} > MAX_SIZE) ||
           ((addr & align) != 32'd0);
  endfunction

  // Index of the final beat: Gets wider than a word span several 4-byte beats.
  function automatic logic [4:0] last_beat(input logic wr, input logic [3:0] size);
    if (wr || size <= 4'd2) return 5'd0;
    return (5'd1 << (size - 4'd2)) - 5'd1;
  endfunction

  assign cmd_ready           = (state == S_IDLE);
  assign channel_a_valid     = (state == S_REQ);
  assign channel_a_bits_param = 3'd0;
  assign rsp_free            = !rsp_valid || rsp_ready;
  assign channel_d_ready     = (state == S_WAIT) && rsp_free;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign d_fire    = channel_d_valid && channel_d_ready;
  assign d_match   = d_fire && (channel_d_bits_source == tag);
  assign beat_last = (beat_cnt == exp_last);

  // A stale beat freezes the timer just as it leaves the beat counter alone.
  assign timeout_fire = TIMEOUT_EN && (state == S_WAIT) && !d_fire &&
                        (timer == TIMER_LAST) && rsp_free;
  assign err_load     = (state == S_ERR) && !err_loaded && rsp_free;
  assign txn_done     = (d_match && beat_last) || timeout_fire;

  assign unused_d_fields = ^{channel_d_bits_param, channel_d_bits_size,
                             channel_d_bits_sink, channel_d_bits_addr_lo};

  always_ff @(posedge clock or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_fire)
                 state_next = cmd_illegal(cmd_write, cmd_size, cmd_address) ? S_ERR : S_REQ;
      S_REQ:   if (channel_a_ready) state_next = S_WAIT;
      S_WAIT:  if (txn_done) state_next = S_IDLE;
      S_ERR:   if (err_loaded && rsp_valid && rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A-channel fields are captured once per command and held through the handshake.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      req_write              <= 1'b0;
      exp_last               <= 5'd0;
      channel_a_bits_opcode  <= 3'd0;
      channel_a_bits_size    <= 4'd0;
      channel_a_bits_address <= 32'd0;
      channel_a_bits_mask    <= 4'd0;
      channel_a_bits_data    <= 32'd0;
    end else if (cmd_fire) begin
      req_write              <= cmd_write;
      exp_last               <= last_beat(cmd_write, cmd_size);
      channel_a_bits_size    <= cmd_size;
      channel_a_bits_address <= cmd_address;
      if (cmd_write) begin
        channel_a_bits_opcode <= (cmd_mask == natural_mask(cmd_size, cmd_address[1:0])) ?
                                 OP_PUT_FULL : OP_PUT_PARTIAL;
        channel_a_bits_mask   <= cmd_mask;
        channel_a_bits_data   <= cmd_data;
      end else begin
        channel_a_bits_opcode <= OP_GET;
        channel_a_bits_mask   <= 4'hF;
        channel_a_bits_data   <= 32'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tag        <= 1'b0;
      beat_cnt   <= 5'd0;
      timer      <= '0;
      err_loaded <= 1'b0;
    end else begin
      if (txn_done) tag <= ~tag;

      if (state == S_REQ && channel_a_ready) begin
        beat_cnt <= 5'd0;
        timer    <= '0;
      end else if (d_match) begin
        beat_cnt <= beat_cnt + 5'd1;
        timer    <= '0;
      end else if (state == S_WAIT && !d_fire && timer != TIMER_LAST) begin
        timer <= timer + 1'b1;
      end

      if (err_load)               err_loaded <= 1'b1;
      else if (state_next != S_ERR) err_loaded <= 1'b0;
    end
  end

  assign channel_a_bits_source = tag;

  // Response register: a matching beat, a timeout or an illegal command loads it;
  // an accepted beat clears it unless a new beat is loaded in the same cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_last  <= 1'b0;
      rsp_error <= 1'b0;
    end else if (d_match) begin
      rsp_valid <= 1'b1;
      rsp_data  <= req_write ? 32'd0 : channel_d_bits_data;
      rsp_last  <= beat_last;
      rsp_error <= channel_d_bits_error ||
                   (channel_d_bits_opcode != (req_write ? OP_ACK : OP_ACK_DATA));
    end else if (timeout_fire || err_load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= 32'd0;
      rsp_last  <= 1'b1;
      rsp_error <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_last  <= 1'b0;
      rsp_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tilelink_ul_master.sv
// Scoreboard bench for tilelink_ul_master: directed commands push expected A requests
// and response beats into queues that independent negedge monitors pop and compare.
`timescale 1ns/1ps

module tb_tilelink_ul_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_address, cmd_data;
  logic [3:0]  cmd_size, cmd_mask;
  logic        channel_a_valid, channel_a_ready;
  logic [2:0]  channel_a_bits_opcode, channel_a_bits_param;
  logic [3:0]  channel_a_bits_size, channel_a_bits_mask;
  logic        channel_a_bits_source;
  logic [31:0] channel_a_bits_address, channel_a_bits_data;
  logic        channel_d_valid, channel_d_ready;
  logic [2:0]  channel_d_bits_opcode;
  logic [1:0]  channel_d_bits_param, channel_d_bits_addr_lo;
  logic [3:0]  channel_d_bits_size;
  logic        channel_d_bits_source, channel_d_bits_sink, channel_d_bits_error;
  logic [31:0] channel_d_bits_data;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_error;
  logic [31:0] rsp_data;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic        src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    bit          chk_data;
  } a_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_exp_t;

  a_exp_t   exp_a[$];
  rsp_exp_t exp_rsp[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int a_cyc  = 0;

  tilelink_ul_master #(.TIMEOUT(8), .MAX_SIZE(6)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_write              (cmd_write),
    .cmd_address            (cmd_address),
    .cmd_size               (cmd_size),
    .cmd_mask               (cmd_mask),
    .cmd_data               (cmd_data),
    .channel_a_valid        (channel_a_valid),
    .channel_a_ready        (channel_a_ready),
    .channel_a_bits_opcode  (channel_a_bits_opcode),
    .channel_a_bits_param   (channel_a_bits_param),
    .channel_a_bits_size    (channel_a_bits_size),
    .channel_a_bits_source  (channel_a_bits_source),
    .channel_a_bits_address (channel_a_bits_address),
    .channel_a_bits_mask    (channel_a_bits_mask),
    .channel_a_bits_data    (channel_a_bits_data),
    .channel_d_valid        (channel_d_valid),
    .channel_d_ready        (channel_d_ready),
    .channel_d_bits_opcode  (channel_d_bits_opcode),
    .channel_d_bits_param   (channel_d_bits_param),
    .channel_d_bits_size    (channel_d_bits_size),
    .channel_d_bits_source  (channel_d_bits_source),
    .channel_d_bits_sink    (channel_d_bits_sink),
    .channel_d_bits_addr_lo (channel_d_bits_addr_lo),
    .channel_d_bits_data    (channel_d_bits_data),
    .channel_d_bits_error   (channel_d_bits_error),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_data               (rsp_data),
    .rsp_last               (rsp_last),
    .rsp_error              (rsp_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A-channel monitor
  always @(negedge clock) begin : a_mon
    a_exp_t e;
    if (reset_n && channel_a_valid && channel_a_ready) begin
      a_cyc = cyc;
      if (exp_a.size() == 0) begin
        check("a_unexpected_valid", 32'(channel_a_valid), 32'd0);
      end else begin
        e = exp_a.pop_front();
        check("a_opcode",  32'(channel_a_bits_opcode), 32'(e.op));
        check("a_param",   32'(channel_a_bits_param),  32'd0);
        check("a_size",    32'(channel_a_bits_size),   32'(e.size));
        check("a_source",  32'(channel_a_bits_source), 32'(e.src));
        check("a_address", channel_a_bits_address,    e.addr);
        check("a_mask",    32'(channel_a_bits_mask),   32'(e.mask));
        if (e.chk_data) check("a_data", channel_a_bits_data, e.data);
      end
    end
  end

  // Response monitor, plus back-pressure rule on channel_d_ready
  always @(negedge clock) begin : rsp_mon
    rsp_exp_t e;
    if (reset_n && rsp_valid && !rsp_ready)
      check("d_ready_while_full", 32'(channel_d_ready), 32'd0);
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected_valid", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_data",  rsp_data,         e.data);
        check("rsp_last",  32'(rsp_last),    32'(e.last));
        check("rsp_error", 32'(rsp_error),   32'(e.err));
      end
    end
  end

  function automatic a_exp_t mk_a(input logic [2:0] op, input logic [3:0] size, input logic src,
                                  input logic [31:0] addr, input logic [3:0] mask,
                                  input logic [31:0] data, input bit chk_data);
    a_exp_t e;
    e.op = op; e.size = size; e.src = src; e.addr = addr;
    e.mask = mask; e.data = data; e.chk_data = chk_data;
    return e;
  endfunction

  function automatic rsp_exp_t mk_rsp(input logic [31:0] data, input logic last, input logic err);
    rsp_exp_t e;
    e.data = data; e.last = last; e.err = err;
    return e;
  endfunction

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] size,
                        input logic [3:0] mask, input logic [31:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
    cmd_size = size; cmd_mask = mask; cmd_data = data;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin n++; @(negedge clock); end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic src, input logic [31:0] data,
                        input logic err);
    int n = 0;
    channel_d_valid = 1'b1; channel_d_bits_opcode = op; channel_d_bits_source = src;
    channel_d_bits_data = data; channel_d_bits_error = err;
    @(negedge clock);
    while (!channel_d_ready && n < 100) begin n++; @(negedge clock); end
    check("d_ready_wait", 32'(channel_d_ready), 32'd1);
    @(posedge clock); #1;
    channel_d_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_a.size() != 0) && n < 200) begin
      n++; @(negedge clock);
    end
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag_s);
    check({tag_s, "_cmd_ready"}, 32'(cmd_ready),              32'd1);
    check({tag_s, "_a_valid"},   32'(channel_a_valid),        32'd0);
    check({tag_s, "_d_ready"},   32'(channel_d_ready),        32'd0);
    check({tag_s, "_rsp_valid"}, 32'(rsp_valid),              32'd0);
    check({tag_s, "_rsp_data"},  rsp_data,                    32'd0);
    check({tag_s, "_rsp_last"},  32'(rsp_last),               32'd0);
    check({tag_s, "_rsp_error"}, 32'(rsp_error),              32'd0);
    check({tag_s, "_a_opcode"},  32'(channel_a_bits_opcode),  32'd0);
    check({tag_s, "_a_source"},  32'(channel_a_bits_source),  32'd0);
    check({tag_s, "_a_address"}, channel_a_bits_address,      32'd0);
    check({tag_s, "_a_mask"},    32'(channel_a_bits_mask),    32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_size = '0;
    cmd_mask = '0; cmd_data = '0;
    channel_a_ready = 1'b1;
    channel_d_valid = 1'b0; channel_d_bits_opcode = '0; channel_d_bits_param = '0;
    channel_d_bits_size = '0; channel_d_bits_source = 1'b0; channel_d_bits_sink = 1'b0;
    channel_d_bits_addr_lo = '0; channel_d_bits_data = '0; channel_d_bits_error = 1'b0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // Single-beat Get, source 0
    exp_a.push_back(mk_a(3'd4, 4'd2, 1'b0, 32'h100, 4'hF, 32'd0, 1'b0));
    exp_rsp.push_back(mk_rsp(32'hDEADBEEF, 1'b1, 1'b0));
    do_cmd(1'b0, 32'h100, 4'd2, 4'h0, 32'd0);
    check("a_valid_latency", 32'(channel_a_valid), 32'd1);
    send_d(3'd1, 1'b0, 32'hDEADBEEF, 1'b0);
    check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    wait_drain();

    // Four-beat Get, source 1, consumer toggling ready
    exp_a.push_back(mk_a(3'd4, 4'd4, 1'b1, 32'h40, 4'hF, 32'd0, 1'b0));
    for (int i = 0; i < 4; i++)
      exp_rsp.push_back(mk_rsp(32'hA000_0000 + 32'(i), (i == 3), 1'b0));
    do_cmd(1'b0, 32'h40, 4'd4, 4'h0, 32'd0);
    fork
      begin
        repeat (24) begin @(posedge clock); #1; rsp_ready = ~rsp_ready; end
      end
      begin
        for (int i = 0; i < 4; i++) send_d(3'd1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
      end
    join
    rsp_ready = 1'b1;
    wait_drain();

    // Byte Put whose mask equals the natural lane -> PutFullData, source 0
    exp_a.push_back(mk_a(3'd0, 4'd0, 1'b0, 32'h3, 4'h8, 32'hAB00_0000, 1'b1));
    exp_rsp.push_back(mk_rsp(32'd0, 1'b1, 1'b0));
    do_cmd(1'b1, 32'h3, 4'd0, 4'h8, 32'hAB00_0000);
    send_d(3'd0, 1'b0, 32'h1111_1111, 1'b0);
    wait_drain();

    // Sparse-mask word Put -> PutPartialData, slave error, source 1
    exp_a.push_back(mk_a(3'd1, 4'd2, 1'b1, 32'h200, 4'h5, 32'h1234_5678, 1'b1));
    exp_rsp.push_back(mk_rsp(32'd0, 1'b1, 1'b1));
    do_cmd(1'b1, 32'h200, 4'd2, 4'h5, 32'h1234_5678);
    send_d(3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_drain();

    // Illegal: write size 3, checked for response latency
    exp_rsp.push_back(mk_rsp(32'd0, 1'b1, 1'b1));
    do_cmd(1'b1, 32'h8, 4'd3, 4'hF, 32'h0);
    @(posedge clock); #1;
    check("err_rsp_latency", 32'(rsp_valid), 32'd1);
    wait_drain();

    // Illegal: misaligned Get, then Get larger than MAX_SIZE
    exp_rsp.push_back(mk_rsp(32'd0, 1'b1, 1'b1));
    do_cmd(1'b0, 32'h102, 4'd2, 4'h0, 32'd0);
    wait_drain();
    exp_rsp.push_back(mk_rsp(32'd0, 1'b1, 1'b1));
    do_cmd(1'b0, 32'h80, 4'd7, 4'h0, 32'd0);
    wait_drain();

    // Timeout: Get with source 0 and no D beat
    exp_a.push_back(mk_a(3'd4, 4'd2, 1'b0, 32'h300, 4'hF, 32'd0, 1'b0));
    exp_rsp.push_back(mk_rsp(32'd0, 1'b1, 1'b1));
    do_cmd(1'b0, 32'h300, 4'd2, 4'h0, 32'd0);
    n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 60) begin n++; @(negedge clock); end
    check("timeout_latency", 32'(cyc - a_cyc), 32'd9);
    wait_drain();

    // Late stale beat (source 0) dropped; next Get completes with source 1
    exp_a.push_back(mk_a(3'd4, 4'd2, 1'b1, 32'h104, 4'hF, 32'd0, 1'b0));
    exp_rsp.push_back(mk_rsp(32'hCAFE_F00D, 1'b1, 1'b0));
    do_cmd(1'b0, 32'h104, 4'd2, 4'h0, 32'd0);
    send_d(3'd1, 1'b0, 32'hBAD0_BAD0, 1'b0);
    send_d(3'd1, 1'b1, 32'hCAFE_F00D, 1'b0);
    wait_drain();

    // Reset during WAIT after 2 of 4 beats
    exp_a.push_back(mk_a(3'd4, 4'd4, 1'b0, 32'h80, 4'hF, 32'd0, 1'b0));
    exp_rsp.push_back(mk_rsp(32'h0B0B_0001, 1'b0, 1'b0));
    exp_rsp.push_back(mk_rsp(32'h0B0B_0002, 1'b0, 1'b0));
    do_cmd(1'b0, 32'h80, 4'd4, 4'h0, 32'd0);
    send_d(3'd1, 1'b0, 32'h0B0B_0001, 1'b0);
    send_d(3'd1, 1'b0, 32'h0B0B_0002, 1'b0);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    exp_a.push_back(mk_a(3'd4, 4'd2, 1'b0, 32'h10, 4'hF, 32'd0, 1'b0));
    exp_rsp.push_back(mk_rsp(32'h55AA_55AA, 1'b1, 1'b0));
    do_cmd(1'b0, 32'h10, 4'd2, 4'h0, 32'd0);
    send_d(3'd1, 1'b0, 32'h55AA_55AA, 1'b0);
    wait_drain();

    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
